video_frame_capture: RTL and testbench
======================================

Name: video_frame_capture

Overview:
- Sink-side counterpart of the video controller. Consumes a pixel/sync/data-enable stream (hdmi_data, hdmi_v, hdmi_h, hdmi_de) and writes one captured frame back into a 1-bit framebuffer.
- Each pixel is reduced to 1 bit by an RGB-sum threshold.
- Used for loopback self-test of the video path and for frame grabbing under CPU control.
- Single-shot: one capture per request, with done and error reporting.

Parameters:
- H_ACTIVE, 800, active pixels per line.
- V_ACTIVE, 600, active lines per frame.
- ADDR_WIDTH, 19, framebuffer address width; must satisfy 2^ADDR_WIDTH >= H_ACTIVE*V_ACTIVE.
- THRESHOLD, 384, pixel is 1 when R+G+B (10-bit unsigned sum) >= THRESHOLD.
- VSYNC_ACTIVE_HIGH, 1, polarity of hdmi_v (1: high = sync active).

Ports:
- clk  in  1  pixel clock; sole clock.
- rst  in  1  synchronous, active-high reset.
- hdmi_data  in  24  pixel {R[23:16],G[15:8],B[7:0]}.
- hdmi_v  in  1  vertical sync.
- hdmi_h  in  1  horizontal sync (monitored only, not used for addressing).
- hdmi_de  in  1  data enable; high during active pixels.
- capture_start  in  1  one-cycle request; honoured only in IDLE.
- capture_abort  in  1  returns to IDLE from any state; no done pulse.
- busy  out  1  high in ARM or CAPTURE.
- capture_done  out  1  one-cycle pulse at frame end.
- line_err  out  1  sticky: some line had a de-run length != H_ACTIVE.
- overflow_err  out  1  sticky: pixels beyond H_ACTIVE*V_ACTIVE were dropped.
- fb_addr  out  ADDR_WIDTH  framebuffer write address.
- fb_wdata  out  1  thresholded pixel.
- fb_we  out  1  write strobe.

Behaviour:
- Reset values: busy=0, capture_done=0, line_err=0, overflow_err=0, fb_addr=0, fb_wdata=0, fb_we=0. State=IDLE, internal counters=0, sync/de history registers cleared.
- Input stage: all inputs are registered once (stage S1).
- vsync leading edge: S1 vsync at active level while the previous S1 vsync was inactive.
- de falling edge: previous S1 de=1 and current S1 de=0.
- State IDLE:
  - capture_start=1 -> ARM.
  - On entering ARM, clear line_err and overflow_err.
- State ARM:
  - Wait for vsync leading edge -> CAPTURE.
  - On that edge: addr counter=0, x counter=0, line counter=0.
- State CAPTURE:
  - For each S1 cycle with de=1: if addr counter < H_ACTIVE*V_ACTIVE, write the pixel. fb_we=1, fb_addr=addr counter, fb_wdata=(R+G+B>=THRESHOLD); then addr+1, x+1.
  - Writes are driven on the cycle after the S1 sample. Total latency from a port pixel to fb_we is 2 cycles.
  - If addr counter >= H_ACTIVE*V_ACTIVE: no write; set overflow_err.
  - On de falling edge: if x != H_ACTIVE, set line_err. Then x=0 and line+1.
  - On the next vsync leading edge: capture_done=1 for exactly one cycle -> IDLE.
  - The frame is not cut short if line < V_ACTIVE. Short frames leave unwritten addresses untouched; this condition is not flagged.
- busy=1 exactly while in ARM or CAPTURE.
- fb_we=0 in all cycles other than active-pixel writes.
- capture_start while busy: ignored.
- capture_start and capture_abort in the same cycle: abort wins; stay or return to IDLE.
- capture_abort: next state IDLE. Any write already registered this cycle still completes. Error flags keep their values.
- rst mid-capture: all state returns to the reset values on the next edge.
- A pixel in the same S1 cycle as the terminating vsync edge is not written (de is low during sync by protocol).

Optional Feature:
- Macro VIDEO_CAPTURE_CHECKSUM_EN.
- Defined:
  - Adds output frame_ones [ADDR_WIDTH-1:0], the count of 1-pixels written in the current capture.
  - Cleared on entering CAPTURE; incremented on each fb_we with fb_wdata=1.
  - Holds its value after capture_done until the next capture starts. Reset 0.
- Not defined: port absent, no counter logic.

Test Plan (H_ACTIVE=4, V_ACTIVE=3, THRESHOLD=384, ADDR_WIDTH=4):
- Reset, then idle stream with no capture_start -> fb_we stays 0, busy=0, all flags 0.
- capture_start; vsync edge; 3 lines of 4 de-pixels (alternating 24'hFFFFFF/24'h000000); vsync edge -> fb_we 12 times, addrs 0..11, data 1,0,1,0,...; capture_done one cycle after the second vsync edge is sampled; line_err=0; frame_ones=6 when the macro is defined.
- Pixel 24'h808080 (sum 384) -> 1; 24'h7F8080 (sum 383) -> 0.
- Line 1 with 3 de-pixels -> line_err=1; line 2 starts at addr 7; frame total 11 writes.
- 4 lines of 4 pixels -> addrs 0..11 written, last 4 pixels not written, overflow_err=1, capture_done still pulses.
- capture_abort during line 2 -> busy=0 next cycle, no capture_done, fb_we stops within 1 cycle; a new capture_start re-arms and clears the flags.

Source files
------------

// File: rtl/video_frame_capture.sv
// Single-shot capture of one video frame into a 1-bit framebuffer (RGB-sum threshold).
// Optional macro VIDEO_CAPTURE_CHECKSUM_EN adds the frame_ones count of 1-pixels written.
module video_frame_capture #(
    parameter int H_ACTIVE          = 800,
    parameter int V_ACTIVE          = 600,
    parameter int ADDR_WIDTH        = 19,
    parameter int THRESHOLD         = 384,
    parameter int VSYNC_ACTIVE_HIGH = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [23:0]           hdmi_data,
    input  logic                  hdmi_v,
    input  logic                  hdmi_h,
    input  logic                  hdmi_de,
    input  logic                  capture_start,
    input  logic                  capture_abort,
    output logic                  busy,
    output logic                  capture_done,
    output logic                  line_err,
    output logic                  overflow_err,
    output logic [ADDR_WIDTH-1:0] fb_addr,
    output logic                  fb_wdata,
    output logic                  fb_we
`ifdef VIDEO_CAPTURE_CHECKSUM_EN
    ,
    output logic [ADDR_WIDTH-1:0] frame_ones
`endif
);

    typedef enum logic [1:0] {IDLE, ARM, CAPTURE} state_t;

    localparam int                  TOTAL_I = H_ACTIVE * V_ACTIVE;
    localparam logic [ADDR_WIDTH:0] TOTAL   = TOTAL_I[ADDR_WIDTH:0];
    localparam logic [15:0]         H_LEN   = H_ACTIVE[15:0];
    localparam logic [9:0]          THR     = THRESHOLD[9:0];

    state_t                state_q, state_d;
    logic [23:0]           data_s1_q, data_s1_d;
    logic                  vact_s1_q, vact_s1_d;
    logic                  h_s1_q, h_s1_d;
    logic                  de_s1_q, de_s1_d;
    logic                  vact_prev_q, vact_prev_d;
    logic                  de_prev_q, de_prev_d;
    logic [ADDR_WIDTH:0]   addr_q, addr_d;
    logic [15:0]           x_q, x_d;
    logic [15:0]           line_q, line_d;
    logic                  line_err_q, line_err_d;
    logic                  overflow_err_q, overflow_err_d;
    logic                  capture_done_q, capture_done_d;
    logic [ADDR_WIDTH-1:0] fb_addr_q, fb_addr_d;
    logic                  fb_wdata_q, fb_wdata_d;
    logic                  fb_we_q, fb_we_d;
    logic [ADDR_WIDTH-1:0] ones_q, ones_d;

    logic       vs_edge, de_fall, pix_bit;
    logic [9:0] pix_sum;
    logic       unused_sig;

    always_comb begin
        data_s1_d      = hdmi_data;
        vact_s1_d      = (VSYNC_ACTIVE_HIGH != 0) ? hdmi_v : ~hdmi_v;
        h_s1_d         = hdmi_h;
        de_s1_d        = hdmi_de;
        vact_prev_d    = vact_s1_q;
        de_prev_d      = de_s1_q;
        state_d        = state_q;
        addr_d         = addr_q;
        x_d            = x_q;
        line_d         = line_q;
        line_err_d     = line_err_q;
        overflow_err_d = overflow_err_q;
        capture_done_d = 1'b0;
        fb_addr_d      = fb_addr_q;
        fb_wdata_d     = fb_wdata_q;
        fb_we_d        = 1'b0;
        ones_d         = ones_q;

        vs_edge    = vact_s1_q & ~vact_prev_q;
        de_fall    = de_prev_q & ~de_s1_q;
        pix_sum    = 10'(data_s1_q[23:16]) + 10'(data_s1_q[15:8]) + 10'(data_s1_q[7:0]);
        pix_bit    = (pix_sum >= THR);
        unused_sig = ^{h_s1_q, line_q};

        case (state_q)
            IDLE: begin
                if (capture_start) begin
                    state_d        = ARM;
                    line_err_d     = 1'b0;
                    overflow_err_d = 1'b0;
                end
            end
            ARM: begin
                if (vs_edge) begin
                    state_d = CAPTURE;
                    addr_d  = '0;
                    x_d     = '0;
                    line_d  = '0;
                    ones_d  = '0;
                end
            end
            CAPTURE: begin
                if (vs_edge) begin
                    capture_done_d = 1'b1;
                    state_d        = IDLE;
                end else begin
                    // x counts every de cycle (saturating) so line length is checked even when writes are dropped
                    if (de_s1_q) begin
                        if (x_q != '1) x_d = x_q + 16'd1;
                        if (addr_q < TOTAL) begin
                            fb_we_d    = 1'b1;
                            fb_addr_d  = addr_q[ADDR_WIDTH-1:0];
                            fb_wdata_d = pix_bit;
                            addr_d     = addr_q + 1'b1;
                            if (pix_bit) ones_d = ones_q + 1'b1;
                        end else begin
                            overflow_err_d = 1'b1;
                        end
                    end
                    if (de_fall) begin
                        if (x_q != H_LEN) line_err_d = 1'b1;
                        x_d    = '0;
                        line_d = line_q + 16'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (capture_abort) begin
            state_d        = IDLE;
            fb_we_d        = 1'b0;
            capture_done_d = 1'b0;
            line_err_d     = line_err_q;
            overflow_err_d = overflow_err_q;
            ones_d         = ones_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            data_s1_q      <= '0;
            vact_s1_q      <= 1'b0;
            h_s1_q         <= 1'b0;
            de_s1_q        <= 1'b0;
            vact_prev_q    <= 1'b0;
            de_prev_q      <= 1'b0;
            addr_q         <= '0;
            x_q            <= '0;
            line_q         <= '0;
            line_err_q     <= 1'b0;
            overflow_err_q <= 1'b0;
            capture_done_q <= 1'b0;
            fb_addr_q      <= '0;
            fb_wdata_q     <= 1'b0;
            fb_we_q        <= 1'b0;
            ones_q         <= '0;
        end else begin
            state_q        <= state_d;
            data_s1_q      <= data_s1_d;
            vact_s1_q      <= vact_s1_d;
            h_s1_q         <= h_s1_d;
            de_s1_q        <= de_s1_d;
            vact_prev_q    <= vact_prev_d;
            de_prev_q      <= de_prev_d;
            addr_q         <= addr_d;
            x_q            <= x_d;
            line_q         <= line_d;
            line_err_q     <= line_err_d;
            overflow_err_q <= overflow_err_d;
            capture_done_q <= capture_done_d;
            fb_addr_q      <= fb_addr_d;
            fb_wdata_q     <= fb_wdata_d;
            fb_we_q        <= fb_we_d;
            ones_q         <= ones_d;
        end
    end

    assign busy         = (state_q != IDLE);
    assign capture_done = capture_done_q;
    assign line_err     = line_err_q;
    assign overflow_err = overflow_err_q;
    assign fb_addr      = fb_addr_q;
    assign fb_wdata     = fb_wdata_q;
    assign fb_we        = fb_we_q;
`ifdef VIDEO_CAPTURE_CHECKSUM_EN
    assign frame_ones   = ones_q;
`else
    logic unused_ones;
    assign unused_ones  = ^ones_q;
`endif

endmodule

// File: tb/tb_video_frame_capture.sv
// Scoreboard bench for video_frame_capture with a 4x3 frame and 4-bit framebuffer.
module tb_video_frame_capture;

    localparam int HA = 4;
    localparam int VA = 3;
    localparam int AW = 4;
    localparam int TH = 384;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [23:0]   hdmi_data = '0;
    logic          hdmi_v = 1'b0, hdmi_h = 1'b0, hdmi_de = 1'b0;
    logic          capture_start = 1'b0, capture_abort = 1'b0;
    logic          busy, capture_done, line_err, overflow_err, fb_wdata, fb_we;
    logic [AW-1:0] fb_addr;
`ifdef VIDEO_CAPTURE_CHECKSUM_EN
    logic [AW-1:0] frame_ones;
`endif

    video_frame_capture #(
        .H_ACTIVE(HA), .V_ACTIVE(VA), .ADDR_WIDTH(AW), .THRESHOLD(TH), .VSYNC_ACTIVE_HIGH(1)
    ) dut (
        .clk(clk), .rst(rst), .hdmi_data(hdmi_data), .hdmi_v(hdmi_v), .hdmi_h(hdmi_h),
        .hdmi_de(hdmi_de), .capture_start(capture_start), .capture_abort(capture_abort),
        .busy(busy), .capture_done(capture_done), .line_err(line_err),
        .overflow_err(overflow_err), .fb_addr(fb_addr), .fb_wdata(fb_wdata), .fb_we(fb_we)
`ifdef VIDEO_CAPTURE_CHECKSUM_EN
        , .frame_ones(frame_ones)
`endif
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0, n_pass = 0;
    int unsigned exp_q[$];
    int unsigned we_cnt = 0, done_cnt = 0;
    int unsigned exp_addr = 0, exp_ones = 0;
    bit          cap_on = 1'b0;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic int unsigned thr(input logic [23:0] d);
        int unsigned s;
        s = int'(d[23:16]) + int'(d[15:8]) + int'(d[7:0]);
        return (s >= TH) ? 1 : 0;
    endfunction

    function automatic logic [23:0] pix(input int mode, input int i);
        logic [23:0] tbl [4];
        if (mode == 0) return (i % 2 == 0) ? 24'hFFFFFF : 24'h000000;
        tbl[0] = 24'h808080; tbl[1] = 24'h7F8080; tbl[2] = 24'hFFFFFF; tbl[3] = 24'h010101;
        return tbl[i % 4];
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (fb_we) begin
                int unsigned e;
                we_cnt++;
                check("sb_has_entry", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("fb_addr", 32'(fb_addr), e >> 1);
                    check("fb_wdata", 32'(fb_wdata), e & 1);
                end
            end
            if (capture_done) done_cnt++;
        end
    end

    task automatic cyc(input logic [23:0] d, input logic v, input logic h, input logic de);
        hdmi_data = d; hdmi_v = v; hdmi_h = h; hdmi_de = de;
        @(posedge clk); #1;
    endtask

    task automatic vsync_pulse();
        cyc('0, 1'b1, 1'b0, 1'b0);
        cyc('0, 1'b1, 1'b0, 1'b0);
        cyc('0, 1'b0, 1'b0, 1'b0);
        cyc('0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_line(input int len, input int mode);
        logic [23:0] d;
        for (int i = 0; i < len; i++) begin
            d = pix(mode, i);
            if (cap_on && exp_addr < HA * VA) begin
                exp_q.push_back(exp_addr * 2 + thr(d));
                exp_ones += thr(d);
                exp_addr++;
            end
            cyc(d, 1'b0, 1'b0, 1'b1);
        end
        cyc('0, 1'b0, 1'b0, 1'b0);
        cyc('0, 1'b0, 1'b1, 1'b0);
        cyc('0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic start_capture();
        capture_start = 1'b1;
        cyc('0, 1'b0, 1'b0, 1'b0);
        capture_start = 1'b0;
        check("busy_after_start", 32'(busy), 1);
        check("line_err_cleared", 32'(line_err), 0);
        check("ovf_cleared", 32'(overflow_err), 0);
    endtask

    task automatic do_frame(input int nl, input int short_line, input int mode);
        int unsigned d0, w0, px;
        d0 = done_cnt; w0 = we_cnt; px = 0;
        start_capture();
        vsync_pulse();
        cap_on = 1'b1; exp_addr = 0; exp_ones = 0;
        for (int l = 0; l < nl; l++) begin
            send_line((l == short_line) ? 3 : 4, mode);
            px += (l == short_line) ? 3 : 4;
        end
        vsync_pulse();
        cap_on = 1'b0;
        cyc('0, 1'b0, 1'b0, 1'b0);
        check("done_pulses", done_cnt - d0, 1);
        check("busy_after_done", 32'(busy), 0);
        check("sb_drained", 32'(exp_q.size()), 0);
        check("write_count", we_cnt - w0, (px > HA * VA) ? HA * VA : px);
        check("overflow_err", 32'(overflow_err), (px > HA * VA) ? 1 : 0);
        if (nl <= VA) check("line_err", 32'(line_err), (short_line >= 0) ? 1 : 0);
`ifdef VIDEO_CAPTURE_CHECKSUM_EN
        check("frame_ones", 32'(frame_ones), exp_ones);
`endif
    endtask

    initial begin
        int unsigned d0;
        repeat (3) cyc('0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(capture_done), 0);
        check("rst_line_err", 32'(line_err), 0);
        check("rst_ovf", 32'(overflow_err), 0);
        check("rst_fb_addr", 32'(fb_addr), 0);
        check("rst_fb_wdata", 32'(fb_wdata), 0);
        check("rst_fb_we", 32'(fb_we), 0);

        // idle video with no request
        vsync_pulse();
        send_line(4, 0);
        send_line(4, 0);
        vsync_pulse();
        check("idle_writes", we_cnt, 0);
        check("idle_busy", 32'(busy), 0);
        check("idle_done", done_cnt, 0);

        do_frame(3, -1, 0);   // alternating white/black
        do_frame(3, -1, 1);   // threshold boundary 384/383
        do_frame(3, 1, 0);    // short line 1
        do_frame(4, -1, 0);   // overflow

        // abort during line 2 with line_err already set
        d0 = done_cnt;
        start_capture();
        vsync_pulse();
        cap_on = 1'b1; exp_addr = 0; exp_ones = 0;
        send_line(4, 0);
        send_line(3, 0);
        capture_abort = 1'b1;
        cap_on = 1'b0;
        cyc('0, 1'b0, 1'b0, 1'b0);
        capture_abort = 1'b0;
        check("abort_busy", 32'(busy), 0);
        check("abort_keeps_line_err", 32'(line_err), 1);
        send_line(4, 0);
        vsync_pulse();
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_sb_drained", 32'(exp_q.size()), 0);

        // start and abort together: stay idle, flags untouched
        capture_start = 1'b1; capture_abort = 1'b1;
        cyc('0, 1'b0, 1'b0, 1'b0);
        capture_start = 1'b0; capture_abort = 1'b0;
        check("start_abort_busy", 32'(busy), 0);
        check("start_abort_line_err", 32'(line_err), 1);

        do_frame(3, -1, 0);   // re-arm clears flags and captures normally

        repeat (3) cyc('0, 1'b0, 1'b0, 1'b0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
